// File: rtl/seq_pkg.sv
// Shared constants and types for the serial pattern detector.
// Legal parameter ranges, default pattern and FSM encoding.
package seq_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;
    localparam int CNT_W_MIN = 2;

    localparam logic [3:0] DEF_PAT = 4'b1011;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with a sticky all-ones flag.
// A clear and an increment on the same edge leave the count at one.
module sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_sat
);

    logic [CNT_W-1:0] r_count;
    logic             r_sat;
    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_count_n;
    logic             w_sat_n;

    // Clear first, then count; the flag follows the new count.
    always_comb begin
        w_base    = i_clr ? '0 : r_count;
        w_count_n = w_base;
        if (i_inc && (w_base != '1)) begin
            w_count_n = w_base + 1'b1;
        end
        w_sat_n = (i_clr ? 1'b0 : r_sat) | (w_count_n == '1);
    end

    // Count and flag registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_count_n;
            r_sat   <= w_sat_n;
        end
    end

    assign o_count = r_count;
    assign o_sat   = r_sat;

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with loadable pattern, optional overlap
// and a saturating match counter. All outputs are registered.
module seq_detect_param
    import seq_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(DEF_PAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic [PAT_W-1:0] pat,
    input  logic             pat_load,
    input  logic             overlap_en,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] counter,
    output logic             cnt_sat
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    state_t           r_state;
    state_t           w_state_n;
    logic [PAT_W-1:0] r_hist;
    logic [PAT_W-1:0] w_hist_n;
    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-1:0] w_pat_n;
    logic [FW-1:0]    r_fill;
    logic [FW-1:0]    w_fill_n;
    logic             r_out;
    logic             w_out_n;

    logic [PAT_W-1:0] w_shift;
    logic [FW-1:0]    w_fill_inc;
    logic             w_hit;

    assign w_shift    = {r_hist[PAT_W-2:0], in};
    assign w_fill_inc = (r_state == ARMED) ? FULL : r_fill + 1'b1;
    assign w_hit      = in_valid && !pat_load &&
                        (w_fill_inc == FULL) && (w_shift == r_pat);

    // Next-state logic: pattern load beats a valid bit; no-overlap
    // restarts the fill count after a hit.
    always_comb begin
        w_state_n = r_state;
        w_hist_n  = r_hist;
        w_pat_n   = r_pat;
        w_fill_n  = r_fill;
        w_out_n   = 1'b0;
        if (pat_load) begin
            w_pat_n   = pat;
            w_hist_n  = '0;
            w_fill_n  = '0;
            w_state_n = FILL;
        end else if (in_valid) begin
            w_hist_n  = w_shift;
            w_fill_n  = w_fill_inc;
            w_state_n = (w_fill_inc == FULL) ? ARMED : FILL;
            w_out_n   = w_hit;
            if (w_hit && !overlap_en) begin
                w_fill_n  = '0;
                w_state_n = FILL;
            end
        end
    end

    // Detector state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL;
            r_hist  <= '0;
            r_pat   <= DEFAULT_PAT;
            r_fill  <= '0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_hist  <= w_hist_n;
            r_pat   <= w_pat_n;
            r_fill  <= w_fill_n;
            r_out   <= w_out_n;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_hit),
        .i_clr   (cnt_clr),
        .o_count (counter),
        .o_sat   (cnt_sat)
    );

    assign out = r_out;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param (PAT_W=4, CNT_W=2).
// Driver queues hand-computed results; monitor checks each cycle.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       din = 1'b0;
    logic [3:0] pat = 4'b0000;
    logic       pat_load = 1'b0;
    logic       overlap_en = 1'b1;
    logic       cnt_clr = 1'b0;
    logic       dout;
    logic [1:0] counter;
    logic       cnt_sat;

    typedef struct {
        logic [3:0] v;
        int         id;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   step_id = 0;

    seq_detect_param #(
        .PAT_W       (4),
        .CNT_W       (2),
        .DEFAULT_PAT (4'b1011)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in         (din),
        .pat        (pat),
        .pat_load   (pat_load),
        .overlap_en (overlap_en),
        .cnt_clr    (cnt_clr),
        .out        (dout),
        .counter    (counter),
        .cnt_sat    (cnt_sat)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus its expected {out,counter,cnt_sat}.
    task automatic step(input logic v, input logic b, input logic ld,
                        input logic clr, input logic [3:0] p,
                        input logic eo, input logic [1:0] ec,
                        input logic es);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        din      = b;
        pat_load = ld;
        cnt_clr  = clr;
        pat      = p;
        step_id++;
        e.v  = {eo, ec, es};
        e.id = step_id;
        q.push_back(e);
    endtask

    task automatic bit_in(input logic b, input logic eo,
                          input logic [1:0] ec, input logic es);
        step(1'b1, b, 1'b0, 1'b0, 4'b0000, eo, ec, es);
    endtask

    task automatic flush(input logic [3:0] p);
        step(1'b0, 1'b0, 1'b1, 1'b1, p, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [3:0] got,
                       input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", nm, got, want);
        end
    endtask

    // Monitor: pops one expectation per clock, just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if ({dout, counter, cnt_sat} !== e.v) begin
                    bad++;
                    $display("FAIL step%0d: got out/cnt/sat=%b want=%b",
                             e.id, {dout, counter, cnt_sat}, e.v);
                end
            end
        end
    end

    initial begin
        #12;
        chk("reset", {1'b0, dout, counter, cnt_sat}, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        // Overlap on: matches after bits 4 and 7.
        overlap_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
        bit_in(1, 0, 2'd0, 0);
        bit_in(0, 0, 2'd0, 0);
        bit_in(1, 0, 2'd0, 0);
        bit_in(1, 1, 2'd1, 0);
        bit_in(0, 0, 2'd1, 0);
        bit_in(1, 0, 2'd1, 0);
        bit_in(1, 1, 2'd2, 0);

        // Overlap off: single match, trailing 011 does not match.
        flush(4'b1011);
        overlap_en = 1'b0;
        bit_in(1, 0, 2'd0, 0);
        bit_in(0, 0, 2'd0, 0);
        bit_in(1, 0, 2'd0, 0);
        bit_in(1, 1, 2'd1, 0);
        bit_in(0, 0, 2'd1, 0);
        bit_in(1, 0, 2'd1, 0);
        bit_in(1, 0, 2'd1, 0);

        // Saturation with a 2-bit counter.
        flush(4'b1011);
        overlap_en = 1'b1;
        bit_in(1, 0, 2'd0, 0);
        bit_in(0, 0, 2'd0, 0);
        bit_in(1, 0, 2'd0, 0);
        bit_in(1, 1, 2'd1, 0);
        bit_in(0, 0, 2'd1, 0);
        bit_in(1, 0, 2'd1, 0);
        bit_in(1, 1, 2'd2, 0);
        bit_in(0, 0, 2'd2, 0);
        bit_in(1, 0, 2'd2, 0);
        bit_in(1, 1, 2'd3, 1);
        bit_in(0, 0, 2'd3, 1);
        bit_in(1, 0, 2'd3, 1);
        bit_in(1, 1, 2'd3, 1);
        bit_in(0, 0, 2'd3, 1);
        bit_in(1, 0, 2'd3, 1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b0);

        // Valid gaps hold the partial sequence.
        flush(4'b1011);
        bit_in(1, 0, 2'd0, 0);
        bit_in(0, 0, 2'd0, 0);
        bit_in(1, 0, 2'd0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        end
        bit_in(1, 1, 2'd1, 0);

        // Pattern load drops the same-edge bit and flushes history.
        flush(4'b1011);
        bit_in(1, 0, 2'd0, 0);
        bit_in(0, 0, 2'd0, 0);
        bit_in(1, 0, 2'd0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b0, 2'd0, 1'b0);
        bit_in(0, 0, 2'd0, 0);
        bit_in(1, 0, 2'd0, 0);
        bit_in(1, 0, 2'd0, 0);
        bit_in(0, 1, 2'd1, 0);
        bit_in(1, 0, 2'd1, 0);
        bit_in(0, 0, 2'd1, 0);
        bit_in(1, 0, 2'd1, 0);
        bit_in(1, 0, 2'd1, 0);

        // Asynchronous reset right after a match pulse.
        flush(4'b1011);
        bit_in(1, 0, 2'd0, 0);
        bit_in(0, 0, 2'd0, 0);
        bit_in(1, 0, 2'd0, 0);
        bit_in(1, 1, 2'd1, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst", {1'b0, dout, counter, cnt_sat}, 4'b0000);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_hold", {1'b0, dout, counter, cnt_sat}, 4'b0000);
        rst = 1'b1;
        bit_in(1, 0, 2'd0, 0);
        bit_in(0, 0, 2'd0, 0);
        bit_in(1, 0, 2'd0, 0);
        bit_in(1, 1, 2'd1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 4'(q.size()), 4'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
